// File: rtl/counter_seq_monitor.sv
// Watches a free-running counter's output and flags any step that is not +1 or a clear-to-zero.
// Also reports threshold hits and natural rollovers; every output is registered, one cycle after the sampling edge.
module counter_seq_monitor #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              cnt_rst,
  input  logic [WIDTH-1:0]  thresh,
  input  logic              clr_err,
  output logic              hit,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               rst_d_q, rst_d_d;
  logic               hit_q, hit_d;
  logic               wrap_q, wrap_d;
  logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   prev_inc;
  logic               legal;
  logic               rollover;

  assign prev_inc = prev_q + Q_ONE;
  assign legal    = (q_in == prev_inc) || ((q_in == '0) && rst_d_q);
  // A zero produced by the upstream clear is legal but is not a rollover.
  assign rollover = (prev_q == '1) && (q_in == '0) && !rst_d_q;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    rst_d_d    = rst_d_q;
    hit_d      = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;

    if (!en) begin
      state_d = IDLE;
    end else begin
      prev_d  = q_in;
      rst_d_d = cnt_rst;
      case (state_q)
        IDLE:  state_d = SYNC;
        SYNC:  state_d = TRACK;
        TRACK: begin
          if (legal) begin
            hit_d  = (q_in == thresh);
            wrap_d = rollover;
            if (rollover && (wrap_cnt_q != '1)) begin
              wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
            end
          end else if (!clr_err) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        ERROR: begin
          if (clr_err) begin
            state_d = SYNC;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear takes priority over any error or wrap raised on the same edge.
    if (clr_err) begin
      wrap_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      rst_d_q    <= 1'b0;
      hit_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      rst_d_q    <= rst_d_d;
      hit_q      <= hit_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
    end
  end

  assign hit      = hit_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign err      = err_q;
  assign state    = state_q;

endmodule

// File: doc/counter_seq_monitor.md
COUNTER_SEQ_MONITOR -- requirements
Module: counter_seq_monitor

Interface
REQ-001 Parameter WIDTH, default 8: width of the monitored count value and threshold.
REQ-002 Parameter WRAP_W, default 16: width of the wrap counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  monitor enable; when low, the monitor is idle.
REQ-006 q_in  input  WIDTH  count value sampled from the upstream free-running counter.
REQ-007 cnt_rst  input  1  copy of the upstream counter's active-high synchronous clear.
REQ-008 thresh  input  WIDTH  match threshold compared against q_in.
REQ-009 clr_err  input  1  clears the sticky error and the wrap count.
REQ-010 hit  output  1  one-cycle pulse: a legal sample equalled thresh.
REQ-011 wrap  output  1  one-cycle pulse: a legal all-ones to zero rollover occurred.
REQ-012 wrap_cnt  output  WRAP_W  number of rollovers, saturating.
REQ-013 err  output  1  sticky sequence-violation flag.
REQ-014 state  output  2  FSM state: IDLE=0, SYNC=1, TRACK=2, ERROR=3.

Function
REQ-015 The block SHALL register q_in as prev and cnt_rst as rst_d every cycle that en=1.
REQ-016 All outputs SHALL be registered; hit and wrap SHALL appear one cycle after the sampling edge.
REQ-017 In TRACK, a sample is legal if q_in == (prev+1) mod 2^WIDTH, or if q_in == 0 and rst_d == 1.
REQ-018 FSM transitions: IDLE->SYNC when en=1; SYNC->TRACK on the next edge with en=1, capturing prev with no check; TRACK->ERROR on an illegal sample; ERROR->SYNC when clr_err=1.
REQ-019 From any state, en=0 SHALL force IDLE on the next edge; err and wrap_cnt SHALL keep their values.
REQ-020 hit SHALL pulse only for a legal TRACK sample with q_in == thresh, including thresh=0 reached via cnt_rst.
REQ-021 wrap SHALL pulse only for a legal TRACK sample with prev = all-ones, q_in = 0 and rst_d = 0.
REQ-022 A reset-caused zero SHALL NOT count as a wrap.
REQ-023 wrap_cnt SHALL increment with each wrap pulse and saturate at 2^WRAP_W-1 without rolling over.
REQ-024 err SHALL set on the sample that causes TRACK->ERROR and remain set until clr_err or reset.
REQ-025 hit and wrap SHALL be 0 in IDLE, SYNC and ERROR.
REQ-026 clr_err SHALL zero wrap_cnt and err in any state.
REQ-027 clr_err in TRACK SHALL NOT change state.
REQ-028 If clr_err coincides with an illegal TRACK sample, clear wins: the state stays TRACK, err=0, and prev still updates.
REQ-029 If clr_err coincides with en=0, the state SHALL go to IDLE and err and wrap_cnt SHALL be cleared.
REQ-030 An illegal sample SHALL still update prev, so that SYNC after clr_err resumes from the current value.

Reset
REQ-031 When rst_n=0 at a clock edge: state=IDLE, hit=0, wrap=0, wrap_cnt=0, err=0, prev=0, rst_d=0.
REQ-032 Reset SHALL override en and clr_err.
REQ-033 Reset asserted mid-TRACK SHALL discard the tracking history; after release, the monitor resyncs via SYNC.

Verification
REQ-034 Enable and lock: en=1, q_in counts 5,6,7 -> state IDLE,SYNC,TRACK; no err.
REQ-035 Threshold hit: thresh=0x10, q_in 0x0E..0x12 -> hit=1 for exactly one cycle, the cycle after the 0x10 sample.
REQ-036 Natural rollover: q_in 0xFE,0xFF,0x00,0x01 -> wrap=1 once and wrap_cnt=1.
REQ-037 Legal clear: cnt_rst=1 with prev=0x40, then q_in=0x00 -> no err, no wrap.
REQ-038 Gap error: q_in 0x20,0x22 -> err=1 and state=ERROR the next cycle.
REQ-039 Error clear and resync: after REQ-038, clr_err=1 -> err=0, wrap_cnt=0, state=SYNC, then TRACK.
REQ-040 Saturation: with WRAP_W=2, drive 5 rollovers -> wrap_cnt stays 3 and wrap still pulses each time.
REQ-041 Disable: en=0 mid-TRACK -> state=IDLE the next cycle and wrap_cnt is unchanged.
REQ-042 Sync reset: rst_n=0 for 1 cycle in ERROR -> all outputs zero and state=IDLE.
